decode_execute_stage: RTL and testbench
=======================================

# decode_execute_stage

Pipeline register between Decode and Execute: it captures decoded operand addresses, register-file data and control bits at each clock edge and presents them to Execute and the forwarding unit as the `AfterD2E` signals. It also owns load-use hazard detection: it inserts a one-cycle bubble and stalls Fetch/Decode when an instruction needs a register that the load now in Execute has not yet returned. A saturating counter records inserted bubbles for performance debug.

## Interface
- `DATA_W`, 16, register/immediate data width
- `PC_W`, 32, program counter width
- `OP_W`, 5, ALU opcode width
- `CNT_W`, 16, stall counter width

- `clk`  in  1  pipeline clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_hold`  in  1  memory stage busy; freeze this register and Fetch/Decode
- `flush`  in  1  branch taken/mispredict; kill the instruction entering Execute
- `d_valid`  in  1  Decode holds a real instruction
- `d_src1`, `d_src2`, `d_dest`  in  3 each  Decode register addresses
- `d_use_src1`, `d_use_src2`  in  1 each  instruction actually reads the source
- `d_rw`, `d_mtr`, `d_mr`, `d_mw`  in  1 each  reg-write, mem-to-reg, mem-read, mem-write
- `d_alu_op`  in  OP_W  ALU operation
- `d_rdata1`, `d_rdata2`, `d_imm`  in  DATA_W each  operand data and immediate
- `d_pc`  in  PC_W  instruction PC
- `e_valid`, `e_src1`, `e_src2`, `e_dest`, `e_rw`, `e_mtr`, `e_mr`, `e_mw`, `e_alu_op`, `e_rdata1`, `e_rdata2`, `e_imm`, `e_pc`  out  widths as the matching inputs  registered Execute-stage copies (`AfterD2E`)
- `stall_fd`  out  1  hold PC and the Fetch/Decode register this cycle
- `bubble`  out  1  a bubble is being inserted on this edge
- `stall_cnt`  out  CNT_W  bubbles inserted since reset, saturating

## Operation
- Load-use hazard (combinational): `lu = e_valid & e_mtr & e_rw & d_valid & ((d_use_src1 & d_src1==e_dest) | (d_use_src2 & d_src2==e_dest))`.
- Priority on each edge, highest first:
  1. `mem_hold`: every `e_*` holds; counter holds; `stall_fd=1`, `bubble=0`.
  2. `flush`: `e_valid`, `e_rw`, `e_mtr`, `e_mr`, `e_mw` load 0; `bubble=1`; counter does not increment. `stall_fd=0` so Fetch redirects.
  3. `lu` and FSM in RUN: control bits load 0 (bubble); FSM goes to LU_STALL; `stall_fd=1`, `bubble=1`; counter increments.
  4. Otherwise capture every `d_*` into `e_*`. `e_valid` takes `d_valid`, and a control bit is written only when `d_valid` is set (otherwise 0).
- FSM, 1-bit: RUN and LU_STALL. LU_STALL returns to RUN on the next edge not blocked by `mem_hold`. While in LU_STALL, `lu` is ignored, because the load has moved to Memory and the forwarding unit supplies the data. At most one bubble is inserted per load.
- `flush` while in LU_STALL forces RUN.
- Bubbles carry don't-care data. The data fields still load from `d_*`; only the control bits are cleared.
- `stall_cnt` stops at all-ones (2^CNT_W−1) and does not wrap.

## Timing
- Latency: one cycle from `d_*` to `e_*`.
- `stall_fd` and `bubble` are combinational from the current `e_*`, `d_*`, FSM state, `mem_hold` and `flush`. There is no combinational path from `e_*` outputs back into themselves.
- Reset, asynchronous, while `rst_n=0`:
  - all `e_*` = 0 and `stall_cnt` = 0
  - FSM = RUN
  - `stall_fd` = `mem_hold` and `bubble` = `flush`, since these two are combinational
- Reset asserted mid-stall clears immediately. The first edge after release behaves as RUN.
- `mem_hold` together with `lu`: hold wins. The bubble is inserted on the first edge after hold drops.

## Structure
- Shared pipeline package:
  - `REG_ADDR_W=3`
  - FSM state enum
  - control-bundle struct (`rw`, `mtr`, `mr`, `mw`, `alu_op`), reused by the E2M and M2W registers
- Sub-module `load_use_detect`: purely combinational `lu` equation, reused by later stall logic.
- FSM, register bank and counter stay in the top module.

## Test plan
- Normal flow: `d_valid=1`, `d_dest=3`, `d_rw=1`, `d_pc=0x10`, no hazards → next edge `e_dest=3`, `e_rw=1`, `e_pc=0x10`; `stall_fd=0` and `stall_cnt=0`.
- Load-use:
  - setup: `e_mtr=e_rw=1`, `e_dest=2`, `d_src1=2`, `d_use_src1=1`
  - current cycle: `stall_fd=1`, `bubble=1`
  - next edge: `e_valid=0`, `stall_cnt=1`, FSM = LU_STALL
  - edge after that: consumer enters Execute with `e_valid=1`
- No false hazard: same setup but `d_use_src1=0`, or `e_mtr=0` → no stall, direct capture.
- `mem_hold=1` for 3 cycles with `lu=1`:
  - `e_*` frozen and `stall_cnt` unchanged throughout the hold
  - after the hold drops, exactly one bubble and `stall_cnt` +1
- `flush=1` during LU_STALL → next edge `e_valid=0`, FSM = RUN, counter unchanged.
- Saturation and reset:
  - preload `stall_cnt=0xFFFF` (force), trigger `lu` → stays `0xFFFF`
  - pulse `rst_n=0` between edges → all outputs 0 at once, before any clock edge

Source files
------------

// File: rtl/decode_execute_stage_pkg.sv
// Shared pipeline definitions for the D2E, E2M and M2W pipeline registers.
// Contents:
//   REG_ADDR_W - architectural register address width
//   ALU_OP_W   - ALU opcode width carried in the control bundle
//   pipe_st_e  - load-use stall FSM state
//   ctrl_t     - per-instruction control bundle (rw, mtr, mr, mw, alu_op)
package decode_execute_stage_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned ALU_OP_W   = 5;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StLuStall = 1'b1
  } pipe_st_e;

  typedef struct packed {
    logic                rw;   // register write
    logic                mtr;  // memory to register
    logic                mr;   // memory read
    logic                mw;   // memory write
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags when the instruction in Decode reads a register that the load
// currently in Execute will only produce after the Memory stage.
// Ports:
//   e_valid, e_mtr, e_rw, e_dest  - instruction in Execute
//   d_valid, d_src1/2, d_use_src1/2 - instruction in Decode
//   lu                            - hazard present
module load_use_detect
  import decode_execute_stage_pkg::*;
(
  input  logic                  e_valid,
  input  logic                  e_mtr,
  input  logic                  e_rw,
  input  logic [REG_ADDR_W-1:0] e_dest,
  input  logic                  d_valid,
  input  logic [REG_ADDR_W-1:0] d_src1,
  input  logic [REG_ADDR_W-1:0] d_src2,
  input  logic                  d_use_src1,
  input  logic                  d_use_src2,
  output logic                  lu
);

  logic hit1;
  logic hit2;

  assign hit1 = d_use_src1 & (d_src1 == e_dest);
  assign hit2 = d_use_src2 & (d_src2 == e_dest);
  assign lu   = e_valid & e_mtr & e_rw & d_valid & (hit1 | hit2);

endmodule

// File: rtl/decode_execute_stage.sv
// Decode -> Execute pipeline register with load-use hazard handling.
// Captures Decode operands/controls each edge and presents them as e_*.
// Inserts one bubble per load-use hazard and stalls Fetch/Decode for it.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   mem_hold            - freeze this register and Fetch/Decode
//   flush               - kill the instruction entering Execute
//   d_*                 - Decode-stage instruction fields
//   e_*                 - registered Execute-stage copies
//   stall_fd            - hold PC and the F/D register this cycle
//   bubble              - a bubble is inserted on this edge
//   stall_cnt           - saturating count of load-use bubbles
module decode_execute_stage
  import decode_execute_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned OP_W   = ALU_OP_W,  // must equal ALU_OP_W
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_hold,
  input  logic                  flush,
  input  logic                  d_valid,
  input  logic [REG_ADDR_W-1:0] d_src1,
  input  logic [REG_ADDR_W-1:0] d_src2,
  input  logic [REG_ADDR_W-1:0] d_dest,
  input  logic                  d_use_src1,
  input  logic                  d_use_src2,
  input  logic                  d_rw,
  input  logic                  d_mtr,
  input  logic                  d_mr,
  input  logic                  d_mw,
  input  logic [OP_W-1:0]       d_alu_op,
  input  logic [DATA_W-1:0]     d_rdata1,
  input  logic [DATA_W-1:0]     d_rdata2,
  input  logic [DATA_W-1:0]     d_imm,
  input  logic [PC_W-1:0]       d_pc,
  output logic                  e_valid,
  output logic [REG_ADDR_W-1:0] e_src1,
  output logic [REG_ADDR_W-1:0] e_src2,
  output logic [REG_ADDR_W-1:0] e_dest,
  output logic                  e_rw,
  output logic                  e_mtr,
  output logic                  e_mr,
  output logic                  e_mw,
  output logic [OP_W-1:0]       e_alu_op,
  output logic [DATA_W-1:0]     e_rdata1,
  output logic [DATA_W-1:0]     e_rdata2,
  output logic [DATA_W-1:0]     e_imm,
  output logic [PC_W-1:0]       e_pc,
  output logic                  stall_fd,
  output logic                  bubble,
  output logic [CNT_W-1:0]      stall_cnt
);

  pipe_st_e state_q, state_d;

  logic                  e_valid_q;
  ctrl_t                 e_ctrl_q;
  ctrl_t                 d_ctrl;
  logic [REG_ADDR_W-1:0] e_src1_q, e_src2_q, e_dest_q;
  logic [DATA_W-1:0]     e_rdata1_q, e_rdata2_q, e_imm_q;
  logic [PC_W-1:0]       e_pc_q;
  logic [CNT_W-1:0]      stall_cnt_q;

  logic lu;
  logic load;        // register bank captures d_* this edge
  logic ctrl_clear;  // captured instruction becomes a bubble
  logic cnt_inc;

  load_use_detect u_load_use_detect (
    .e_valid    (e_valid_q),
    .e_mtr      (e_ctrl_q.mtr),
    .e_rw       (e_ctrl_q.rw),
    .e_dest     (e_dest_q),
    .d_valid    (d_valid),
    .d_src1     (d_src1),
    .d_src2     (d_src2),
    .d_use_src1 (d_use_src1),
    .d_use_src2 (d_use_src2),
    .lu         (lu)
  );

  // Control bits only survive for a real instruction.
  always_comb begin
    d_ctrl        = '0;
    d_ctrl.alu_op = ALU_OP_W'(d_alu_op);
    if (d_valid) begin
      d_ctrl.rw  = d_rw;
      d_ctrl.mtr = d_mtr;
      d_ctrl.mr  = d_mr;
      d_ctrl.mw  = d_mw;
    end
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b1;
    ctrl_clear = 1'b0;
    cnt_inc    = 1'b0;
    stall_fd   = 1'b0;
    bubble     = 1'b0;
    if (mem_hold) begin
      load     = 1'b0;
      stall_fd = 1'b1;
    end else if (flush) begin
      ctrl_clear = 1'b1;
      bubble     = 1'b1;
      state_d    = StRun;
    end else if ((state_q == StRun) && lu) begin
      ctrl_clear = 1'b1;
      bubble     = 1'b1;
      stall_fd   = 1'b1;
      cnt_inc    = 1'b1;
      state_d    = StLuStall;
    end else begin
      // In LuStall the load has moved on; forwarding covers the consumer.
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      e_valid_q  <= 1'b0;
      e_ctrl_q   <= '0;
      e_src1_q   <= '0;
      e_src2_q   <= '0;
      e_dest_q   <= '0;
      e_rdata1_q <= '0;
      e_rdata2_q <= '0;
      e_imm_q    <= '0;
      e_pc_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        e_valid_q     <= d_valid & ~ctrl_clear;
        e_ctrl_q      <= d_ctrl;
        e_src1_q      <= d_src1;
        e_src2_q      <= d_src2;
        e_dest_q      <= d_dest;
        e_rdata1_q    <= d_rdata1;
        e_rdata2_q    <= d_rdata2;
        e_imm_q       <= d_imm;
        e_pc_q        <= d_pc;
        if (ctrl_clear) begin
          e_ctrl_q.rw  <= 1'b0;
          e_ctrl_q.mtr <= 1'b0;
          e_ctrl_q.mr  <= 1'b0;
          e_ctrl_q.mw  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (cnt_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign e_valid   = e_valid_q;
  assign e_src1    = e_src1_q;
  assign e_src2    = e_src2_q;
  assign e_dest    = e_dest_q;
  assign e_rw      = e_ctrl_q.rw;
  assign e_mtr     = e_ctrl_q.mtr;
  assign e_mr      = e_ctrl_q.mr;
  assign e_mw      = e_ctrl_q.mw;
  assign e_alu_op  = OP_W'(e_ctrl_q.alu_op);
  assign e_rdata1  = e_rdata1_q;
  assign e_rdata2  = e_rdata2_q;
  assign e_imm     = e_imm_q;
  assign e_pc      = e_pc_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_execute_stage.sv
module tb_decode_execute_stage;
  import decode_execute_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_hold, flush, d_valid;
  logic [2:0]  d_src1, d_src2, d_dest;
  logic        d_use_src1, d_use_src2, d_rw, d_mtr, d_mr, d_mw;
  logic [4:0]  d_alu_op;
  logic [15:0] d_rdata1, d_rdata2, d_imm;
  logic [31:0] d_pc;
  logic        e_valid;
  logic [2:0]  e_src1, e_src2, e_dest;
  logic        e_rw, e_mtr, e_mr, e_mw;
  logic [4:0]  e_alu_op;
  logic [15:0] e_rdata1, e_rdata2, e_imm;
  logic [31:0] e_pc;
  logic        stall_fd, bubble;
  logic [15:0] stall_cnt;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_execute_stage dut (
    .clk(clk), .rst_n(rst_n), .mem_hold(mem_hold), .flush(flush),
    .d_valid(d_valid), .d_src1(d_src1), .d_src2(d_src2), .d_dest(d_dest),
    .d_use_src1(d_use_src1), .d_use_src2(d_use_src2),
    .d_rw(d_rw), .d_mtr(d_mtr), .d_mr(d_mr), .d_mw(d_mw), .d_alu_op(d_alu_op),
    .d_rdata1(d_rdata1), .d_rdata2(d_rdata2), .d_imm(d_imm), .d_pc(d_pc),
    .e_valid(e_valid), .e_src1(e_src1), .e_src2(e_src2), .e_dest(e_dest),
    .e_rw(e_rw), .e_mtr(e_mtr), .e_mr(e_mr), .e_mw(e_mw), .e_alu_op(e_alu_op),
    .e_rdata1(e_rdata1), .e_rdata2(e_rdata2), .e_imm(e_imm), .e_pc(e_pc),
    .stall_fd(stall_fd), .bubble(bubble), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d_clear();
    d_valid = 0; d_src1 = 0; d_src2 = 0; d_dest = 0;
    d_use_src1 = 0; d_use_src2 = 0;
    d_rw = 0; d_mtr = 0; d_mr = 0; d_mw = 0; d_alu_op = 0;
    d_rdata1 = 0; d_rdata2 = 0; d_imm = 0; d_pc = 0;
  endtask

  // Load into Decode: writes dest from memory.
  task automatic d_load(input logic [2:0] dest, input logic [31:0] pc);
    d_clear();
    d_valid = 1; d_dest = dest; d_rw = 1; d_mtr = 1; d_mr = 1; d_pc = pc;
  endtask

  // ALU consumer reading src1 (and optionally src2).
  task automatic d_alu(input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                       input logic u2, input logic [2:0] dest, input logic [31:0] pc);
    d_clear();
    d_valid = 1; d_src1 = s1; d_use_src1 = u1; d_src2 = s2; d_use_src2 = u2;
    d_dest = dest; d_rw = 1; d_pc = pc;
  endtask

  initial begin
    rst_n = 0; mem_hold = 0; flush = 0;
    d_clear();
    #1;
    // Reset state and combinational pass-through of hold/flush.
    check("rst_e_valid", 32'(e_valid), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_stall_fd", 32'(stall_fd), 32'd0);
    check("rst_bubble", 32'(bubble), 32'd0);
    mem_hold = 1; #1;
    check("rst_stall_fd_hold", 32'(stall_fd), 32'd1);
    mem_hold = 0; flush = 1; #1;
    check("rst_bubble_flush", 32'(bubble), 32'd1);
    flush = 0;
    @(negedge clk);
    rst_n = 1;

    // Normal flow.
    d_clear();
    d_valid = 1; d_dest = 3; d_rw = 1; d_pc = 32'h10; d_alu_op = 5'd5;
    d_rdata1 = 16'h1234; d_imm = 16'h00ab;
    #1;
    check("norm_stall_fd", 32'(stall_fd), 32'd0);
    step();
    check("norm_e_valid", 32'(e_valid), 32'd1);
    check("norm_e_dest", 32'(e_dest), 32'd3);
    check("norm_e_rw", 32'(e_rw), 32'd1);
    check("norm_e_pc", e_pc, 32'h10);
    check("norm_e_alu_op", 32'(e_alu_op), 32'd5);
    check("norm_e_rdata1", 32'(e_rdata1), 32'h1234);
    check("norm_e_imm", 32'(e_imm), 32'h00ab);
    check("norm_stall_cnt", 32'(stall_cnt), 32'd0);

    // Invalid Decode slot: control bits must not be captured.
    d_clear(); d_rw = 1; d_mw = 1; d_pc = 32'h14;
    step();
    check("inv_e_valid", 32'(e_valid), 32'd0);
    check("inv_e_rw", 32'(e_rw), 32'd0);
    check("inv_e_mw", 32'(e_mw), 32'd0);

    // Load-use hazard.
    d_load(3'd2, 32'h20);
    step();
    check("lu_load_e_mtr", 32'(e_mtr), 32'd1);
    d_alu(3'd2, 1'b1, 3'd0, 1'b0, 3'd4, 32'h24);
    #1;
    check("lu_stall_fd", 32'(stall_fd), 32'd1);
    check("lu_bubble", 32'(bubble), 32'd1);
    step();
    check("lu_bub_e_valid", 32'(e_valid), 32'd0);
    check("lu_bub_e_rw", 32'(e_rw), 32'd0);
    check("lu_bub_cnt", 32'(stall_cnt), 32'd1);
    check("lu_bub_state", 32'(dut.state_q), 32'(StLuStall));
    check("lu_bub_stall_fd", 32'(stall_fd), 32'd0);
    step();
    check("lu_cons_e_valid", 32'(e_valid), 32'd1);
    check("lu_cons_e_dest", 32'(e_dest), 32'd4);
    check("lu_cons_e_pc", e_pc, 32'h24);
    check("lu_cons_state", 32'(dut.state_q), 32'(StRun));
    check("lu_cons_cnt", 32'(stall_cnt), 32'd1);

    // No false hazard: source not used.
    d_load(3'd2, 32'h30);
    step();
    d_alu(3'd2, 1'b0, 3'd6, 1'b1, 3'd5, 32'h34);
    #1;
    check("nf_unused_stall_fd", 32'(stall_fd), 32'd0);
    step();
    check("nf_unused_e_valid", 32'(e_valid), 32'd1);
    check("nf_unused_e_pc", e_pc, 32'h34);
    // No false hazard: producer in Execute is not a load (e_mtr=0).
    d_alu(3'd5, 1'b1, 3'd5, 1'b1, 3'd6, 32'h38);
    #1;
    check("nf_nomtr_stall_fd", 32'(stall_fd), 32'd0);
    check("nf_nomtr_bubble", 32'(bubble), 32'd0);
    step();
    check("nf_nomtr_e_pc", e_pc, 32'h38);
    check("nf_cnt", 32'(stall_cnt), 32'd1);

    // mem_hold for 3 cycles with a pending hazard (via src2).
    d_load(3'd2, 32'h40);
    step();
    d_alu(3'd0, 1'b0, 3'd2, 1'b1, 3'd7, 32'h44);
    mem_hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_stall_fd", 32'(stall_fd), 32'd1);
      check("hold_bubble", 32'(bubble), 32'd0);
      step();
      check("hold_e_pc", e_pc, 32'h40);
      check("hold_e_mtr", 32'(e_mtr), 32'd1);
      check("hold_cnt", 32'(stall_cnt), 32'd1);
    end
    mem_hold = 0;
    #1;
    check("hold_rel_bubble", 32'(bubble), 32'd1);
    check("hold_rel_stall_fd", 32'(stall_fd), 32'd1);
    step();
    check("hold_bub_e_valid", 32'(e_valid), 32'd0);
    check("hold_bub_cnt", 32'(stall_cnt), 32'd2);
    step();
    check("hold_cons_e_valid", 32'(e_valid), 32'd1);
    check("hold_cons_e_pc", e_pc, 32'h44);
    check("hold_cons_cnt", 32'(stall_cnt), 32'd2);

    // Flush while in LuStall.
    d_load(3'd1, 32'h50);
    step();
    d_alu(3'd1, 1'b1, 3'd0, 1'b0, 3'd3, 32'h54);
    step();
    check("fl_pre_state", 32'(dut.state_q), 32'(StLuStall));
    check("fl_pre_cnt", 32'(stall_cnt), 32'd3);
    d_alu(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 32'h58);
    flush = 1;
    #1;
    check("fl_bubble", 32'(bubble), 32'd1);
    check("fl_stall_fd", 32'(stall_fd), 32'd0);
    step();
    flush = 0;
    check("fl_e_valid", 32'(e_valid), 32'd0);
    check("fl_e_rw", 32'(e_rw), 32'd0);
    check("fl_e_pc", e_pc, 32'h58);
    check("fl_state", 32'(dut.state_q), 32'(StRun));
    check("fl_cnt", 32'(stall_cnt), 32'd3);

    // Counter saturation.
    d_load(3'd6, 32'h60);
    step();
    force dut.stall_cnt_q = 16'hffff;
    #1;
    release dut.stall_cnt_q;
    check("sat_pre", 32'(stall_cnt), 32'hffff);
    d_alu(3'd6, 1'b1, 3'd0, 1'b0, 3'd2, 32'h64);
    #1;
    check("sat_bubble", 32'(bubble), 32'd1);
    step();
    check("sat_cnt", 32'(stall_cnt), 32'hffff);
    check("sat_state", 32'(dut.state_q), 32'(StLuStall));

    // Asynchronous reset mid-stall, between edges.
    #2;
    rst_n = 0;
    #1;
    check("arst_e_valid", 32'(e_valid), 32'd0);
    check("arst_e_pc", e_pc, 32'h0);
    check("arst_e_dest", 32'(e_dest), 32'd0);
    check("arst_cnt", 32'(stall_cnt), 32'd0);
    check("arst_state", 32'(dut.state_q), 32'(StRun));
    @(negedge clk);
    rst_n = 1;
    d_alu(3'd1, 1'b1, 3'd0, 1'b0, 3'd5, 32'h70);
    step();
    check("post_rst_e_valid", 32'(e_valid), 32'd1);
    check("post_rst_e_pc", e_pc, 32'h70);
    check("post_rst_state", 32'(dut.state_q), 32'(StRun));

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
